// File: rtl/psum_path_stage_gen_pkg.sv
// -----------------------------------------------------------------------------
// psum_path_stage_gen_pkg
// Shared PE psum configuration: tag type, pass mode, FSM state encoding and
// the per-lane add used by ACCUM mode.
// -----------------------------------------------------------------------------
package psum_path_stage_gen_pkg;

    localparam int unsigned PSUM_TAGW = 8;

    typedef logic [PSUM_TAGW-1:0] psum_tag_t;

    typedef enum logic {
        MODE_MERGE = 1'b0,
        MODE_ACCUM = 1'b1
    } psum_mode_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } psum_state_e;

    // Adds two sign-extended lanes of width w. With sat set the result is
    // clamped to the signed w-bit range; otherwise the caller keeps the low
    // w bits, which wraps.
    function automatic logic signed [63:0] psum_lane_add(
        input logic signed [63:0] a,
        input logic signed [63:0] b,
        input int unsigned        w,
        input logic               sat
    );
        logic signed [64:0] s;
        logic signed [64:0] hi;
        logic signed [64:0] lo;
        s  = {a[63], a} + {b[63], b};
        hi = (65'sd1 <<< (w - 1)) - 65'sd1;
        lo = -(65'sd1 <<< (w - 1));
        if (sat && (s > hi)) begin
            return hi[63:0];
        end else if (sat && (s < lo)) begin
            return lo[63:0];
        end
        return s[63:0];
    endfunction

endpackage

// File: rtl/psum_path_stage_gen_obuf.sv
// -----------------------------------------------------------------------------
// psum_obuf
// Synchronous FIFO decoupling the psum stage from the downstream POUT port.
//   clk, rst_n : clock, async active-low reset
//   flush      : empty the FIFO (dominates push/pop)
//   push, din  : write one entry (accepted when not full, or full with pop)
//   pop        : drop the head (ignored when empty)
//   dout       : head entry, zero when empty
//   count      : occupancy, empty
// No bypass: an entry pushed into an empty FIFO is visible the next cycle.
// -----------------------------------------------------------------------------
module psum_obuf #(
    parameter int DEPTH = 4,
    parameter int DW    = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic                       push,
    input  logic [DW-1:0]              din,
    input  logic                       pop,
    output logic [DW-1:0]              dout,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       empty
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [DW-1:0] mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          full;
    logic          do_push;
    logic          do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop && !empty && !flush;
    assign do_push = push && !flush && (!full || do_pop);
    assign dout    = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= (wr_ptr == PW'(DEPTH-1)) ? '0 : wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= (rd_ptr == PW'(DEPTH-1)) ? '0 : rd_ptr + 1'b1;
            end
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

endmodule

// File: rtl/psum_path_stage_gen.sv
// -----------------------------------------------------------------------------
// psum_path_stage_gen
// Partial-sum path stage: reads PP entries in address order behind the SS
// writer, merges or accumulates them with LPE beats, and delivers results
// through an output FIFO on the POUT rdy/ack port.
//   i_start/i_mode/i_size/i_tag : start a pass (sampled in IDLE)
//   i_stall, i_abort            : freeze issue / flush and return to IDLE
//   o_busy, o_done              : pass status, one-cycle completion pulse
//   SS_rdy/SS_ack               : SS writer handshake (addresses 0..size-1)
//   o_pp_read/o_pp_raddr/i_pp_psum : PP read port, data one cycle later
//   LPE_rdy/LPE_ack/i_lpe_*     : left-PE beat input
//   POUT_rdy/POUT_ack/o_pout_*  : output FIFO head
//
//   state | meaning
//   ------+--------------------------------------------------------------
//   IDLE  | no pass; LPE beats pass straight through
//   RUN   | pass active; SS acks, PP reads, MERGE/ACCUM issue
//   DONE  | one cycle, o_done high, then back to IDLE
// -----------------------------------------------------------------------------
module psum_path_stage_gen
    import psum_path_stage_gen_pkg::*;
#(
    parameter int PEROW      = 4,
    parameter int PSUMDWD    = 16,
    parameter int ADDRW      = 6,
    parameter int TAGW       = 8,
    parameter int OBUF_DEPTH = 4,
    parameter int SAT        = 1
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_start,
    input  logic                     i_mode,
    input  logic [ADDRW:0]           i_size,
    input  logic [TAGW-1:0]          i_tag,
    input  logic                     i_stall,
    input  logic                     i_abort,
    output logic                     o_busy,
    output logic                     o_done,
    input  logic                     SS_rdy,
    output logic                     SS_ack,
    output logic                     o_pp_read,
    output logic [ADDRW-1:0]         o_pp_raddr,
    input  logic [PEROW*PSUMDWD-1:0] i_pp_psum,
    input  logic                     LPE_rdy,
    output logic                     LPE_ack,
    input  logic [PEROW*PSUMDWD-1:0] i_lpe_psum,
    input  logic [TAGW-1:0]          i_lpe_tag,
    output logic                     POUT_rdy,
    input  logic                     POUT_ack,
    output logic [PEROW*PSUMDWD-1:0] o_pout_psum,
    output logic [TAGW-1:0]          o_pout_tag
);
    localparam int DW = PEROW * PSUMDWD;
    localparam int CW = $clog2(OBUF_DEPTH+1);

    psum_state_e     state;
    psum_mode_e      mode_q;
    logic [ADDRW:0]  size_q;
    logic [TAGW-1:0] tag_q;
    logic [ADDRW:0]  ss_cnt;
    logic [ADDRW:0]  rd_idx;
    logic [ADDRW:0]  emit_cnt;
    logic            pp_pri;     // PP wins the next MERGE conflict

    // one-beat stage register between issue and FIFO push
    logic            st_vld;
    logic            st_pp;
    logic            st_acc;
    logic [DW-1:0]   st_data;
    logic [TAGW-1:0] st_tag;

    logic [CW-1:0]   fifo_cnt;
    logic            fifo_empty;
    logic            run;
    logic            credit;
    logic            pp_ok;
    logic            lpe_ok;
    logic            conflict;
    logic            issue_pp;
    logic            issue_lpe;
    logic            push;
    logic [DW-1:0]   acc_data;
    logic [DW-1:0]   push_data;

    assign run    = (state == ST_RUN);
    // In-flight beat is counted so a push one cycle later always has a slot.
    assign credit = (int'(fifo_cnt) + int'(st_vld)) < OBUF_DEPTH;
    assign pp_ok  = run && !i_stall && !i_abort && (rd_idx < ss_cnt) &&
                    (rd_idx < size_q) && credit;
    assign lpe_ok = LPE_rdy && credit && !i_stall && !i_abort;

    always_comb begin
        issue_pp  = 1'b0;
        issue_lpe = 1'b0;
        conflict  = 1'b0;
        if (run && (mode_q == MODE_ACCUM)) begin
            issue_pp  = pp_ok && LPE_rdy;
            issue_lpe = issue_pp;
        end else if (run) begin
            conflict  = pp_ok && lpe_ok;
            issue_pp  = pp_ok && (!lpe_ok || pp_pri);
            issue_lpe = lpe_ok && (!pp_ok || !pp_pri);
        end else begin
            issue_lpe = lpe_ok;
        end
    end

    assign o_pp_read  = issue_pp;
    assign o_pp_raddr = issue_pp ? rd_idx[ADDRW-1:0] : '0;
    assign LPE_ack    = issue_lpe;
    assign SS_ack     = run && !i_stall && !i_abort && (ss_cnt < size_q);
    assign o_busy     = (state != ST_IDLE);
    assign o_done     = (state == ST_DONE) && !i_abort;

    always_comb begin
        acc_data = '0;
        for (int l = 0; l < PEROW; l++) begin
            acc_data[l*PSUMDWD +: PSUMDWD] = PSUMDWD'(psum_lane_add(
                64'(signed'(i_pp_psum[l*PSUMDWD +: PSUMDWD])),
                64'(signed'(st_data[l*PSUMDWD +: PSUMDWD])),
                PSUMDWD, SAT != 0));
        end
    end

    assign push      = st_vld && !i_abort;
    assign push_data = st_pp ? (st_acc ? acc_data : i_pp_psum) : st_data;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state    <= ST_IDLE;
            mode_q   <= MODE_MERGE;
            size_q   <= '0;
            tag_q    <= '0;
            ss_cnt   <= '0;
            rd_idx   <= '0;
            emit_cnt <= '0;
            pp_pri   <= 1'b1;
            st_vld   <= 1'b0;
            st_pp    <= 1'b0;
            st_acc   <= 1'b0;
            st_data  <= '0;
            st_tag   <= '0;
        end else if (i_abort) begin
            state    <= ST_IDLE;
            ss_cnt   <= '0;
            rd_idx   <= '0;
            emit_cnt <= '0;
            st_vld   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (i_start) begin
                        mode_q <= psum_mode_e'(i_mode);
                        size_q <= i_size;
                        tag_q  <= i_tag;
                        state  <= (i_size == '0) ? ST_DONE : ST_RUN;
                    end
                end
                ST_RUN: begin
                    if ((emit_cnt == size_q) && !st_vld && fifo_empty) begin
                        state <= ST_DONE;
                    end
                end
                default: state <= ST_IDLE;
            endcase

            if (!run) begin
                ss_cnt   <= '0;
                rd_idx   <= '0;
                emit_cnt <= '0;
            end else begin
                if (SS_rdy && SS_ack) ss_cnt <= ss_cnt + 1'b1;
                if (issue_pp)         rd_idx <= rd_idx + 1'b1;
                if (push && st_pp)    emit_cnt <= emit_cnt + 1'b1;
            end

            if (conflict) pp_pri <= issue_lpe;

            st_vld <= issue_pp || issue_lpe;
            st_pp  <= issue_pp;
            st_acc <= issue_pp && issue_lpe;
            st_tag <= issue_pp ? tag_q : i_lpe_tag;
            if (issue_lpe) st_data <= i_lpe_psum;
        end
    end

    psum_obuf #(
        .DEPTH (OBUF_DEPTH),
        .DW    (DW + TAGW)
    ) u_obuf (
        .clk   (i_clk),
        .rst_n (i_rst_n),
        .flush (i_abort),
        .push  (push),
        .din   ({push_data, st_tag}),
        .pop   (POUT_ack),
        .dout  ({o_pout_psum, o_pout_tag}),
        .count (fifo_cnt),
        .empty (fifo_empty)
    );

    assign POUT_rdy = !fifo_empty;

endmodule

// File: tb/tb_psum_path_stage_gen.sv
module tb_psum_path_stage_gen;
    localparam int DW = 64;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic          i_start = 0, i_mode = 0, i_stall = 0, i_abort = 0;
    logic [6:0]    i_size = '0;
    logic [7:0]    i_tag = '0, i_lpe_tag = '0;
    logic          SS_rdy = 0, LPE_rdy = 0, POUT_ack = 0;
    logic [DW-1:0] i_pp_psum = '0, i_lpe_psum = '0;

    logic          o_busy, o_done, SS_ack, o_pp_read, LPE_ack, POUT_rdy;
    logic [5:0]    o_pp_raddr;
    logic [DW-1:0] o_pout_psum;
    logic [7:0]    o_pout_tag;

    logic          w_busy, w_done, w_ss_ack, w_pp_read, w_lpe_ack, w_pout_rdy;
    logic [5:0]    w_pp_raddr;
    logic [DW-1:0] w_pout_psum;
    logic [7:0]    w_pout_tag;

    psum_path_stage_gen #(.PEROW(4), .PSUMDWD(16), .ADDRW(6), .TAGW(8),
                          .OBUF_DEPTH(4), .SAT(1)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(i_start), .i_mode(i_mode),
        .i_size(i_size), .i_tag(i_tag), .i_stall(i_stall), .i_abort(i_abort),
        .o_busy(o_busy), .o_done(o_done), .SS_rdy(SS_rdy), .SS_ack(SS_ack),
        .o_pp_read(o_pp_read), .o_pp_raddr(o_pp_raddr), .i_pp_psum(i_pp_psum),
        .LPE_rdy(LPE_rdy), .LPE_ack(LPE_ack), .i_lpe_psum(i_lpe_psum),
        .i_lpe_tag(i_lpe_tag), .POUT_rdy(POUT_rdy), .POUT_ack(POUT_ack),
        .o_pout_psum(o_pout_psum), .o_pout_tag(o_pout_tag));

    psum_path_stage_gen #(.PEROW(4), .PSUMDWD(16), .ADDRW(6), .TAGW(8),
                          .OBUF_DEPTH(4), .SAT(0)) dut_w (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(i_start), .i_mode(i_mode),
        .i_size(i_size), .i_tag(i_tag), .i_stall(i_stall), .i_abort(i_abort),
        .o_busy(w_busy), .o_done(w_done), .SS_rdy(SS_rdy), .SS_ack(w_ss_ack),
        .o_pp_read(w_pp_read), .o_pp_raddr(w_pp_raddr), .i_pp_psum(i_pp_psum),
        .LPE_rdy(LPE_rdy), .LPE_ack(w_lpe_ack), .i_lpe_psum(i_lpe_psum),
        .i_lpe_tag(i_lpe_tag), .POUT_rdy(w_pout_rdy), .POUT_ack(POUT_ack),
        .o_pout_psum(w_pout_psum), .o_pout_tag(w_pout_tag));

    int total = 0;
    int bad = 0;

    typedef struct {
        logic [DW-1:0] d;
        logic [7:0]    t;
    } beat_t;

    beat_t         exp_q[$];
    beat_t         exp_wq[$];
    beat_t         mon_b;
    logic [DW-1:0] pp_mem [64];
    logic [DW-1:0] lpe_vec [8];
    logic [7:0]    lpe_tagv [8];
    int            ss_model = 0, rd_model = 0, done_cnt = 0, cyc = 0;
    int            out_cnt = 0, out_cntw = 0;
    int            ss_cyc [16];
    int            rd_cyc [16];
    logic [DW-1:0] out_log [16];
    logic [DW-1:0] out_logw [16];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h required %h", nm, act, req);
        end
    endtask

    function automatic logic [15:0] add_lane(input logic [15:0] a, input logic [15:0] b,
                                             input bit sat);
        int s;
        s = int'($signed(a)) + int'($signed(b));
        if (sat && s > 32767)  s = 32767;
        if (sat && s < -32768) s = -32768;
        return s[15:0];
    endfunction

    function automatic logic [DW-1:0] accum(input logic [DW-1:0] p, input logic [DW-1:0] l,
                                            input bit sat);
        logic [DW-1:0] r;
        r = '0;
        for (int k = 0; k < 4; k++) r[k*16 +: 16] = add_lane(p[k*16 +: 16], l[k*16 +: 16], sat);
        return r;
    endfunction

    task automatic push_exp(input logic [DW-1:0] d, input logic [DW-1:0] dw, input logic [7:0] t);
        beat_t b;
        b.d = d;  b.t = t; exp_q.push_back(b);
        b.d = dw; exp_wq.push_back(b);
    endtask

    // PP memory: answers a read one cycle after the strobe.
    always begin : pp_mem_model
        logic       rd;
        logic [5:0] a;
        @(negedge clk);
        rd = o_pp_read;
        a  = o_pp_raddr;
        @(posedge clk);
        #1;
        if (rd) i_pp_psum = pp_mem[a];
    end

    always @(negedge clk) begin
        cyc++;
        if (rst_n) begin
            if (POUT_rdy && POUT_ack) begin
                if (exp_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL pout_unexpected: got %h tag %h required no beat", o_pout_psum, o_pout_tag);
                end else begin
                    mon_b = exp_q.pop_front();
                    chk("pout_psum", o_pout_psum, mon_b.d);
                    chk("pout_tag", 64'(o_pout_tag), 64'(mon_b.t));
                    if (out_cnt < 16) out_log[out_cnt] = o_pout_psum;
                    out_cnt++;
                end
            end
            if (w_pout_rdy && POUT_ack) begin
                if (exp_wq.size() == 0) begin
                    total++; bad++;
                    $display("FAIL pout_w_unexpected: got %h required no beat", w_pout_psum);
                end else begin
                    mon_b = exp_wq.pop_front();
                    chk("pout_w_psum", w_pout_psum, mon_b.d);
                    if (out_cntw < 16) out_logw[out_cntw] = w_pout_psum;
                    out_cntw++;
                end
            end
            if (o_pp_read) begin
                chk("pp_raddr", 64'(o_pp_raddr), 64'(rd_model[5:0]));
                chk("rd_behind_ss", 64'(rd_model < ss_model), 64'd1);
                if (rd_model < 16) rd_cyc[rd_model] = cyc;
                rd_model++;
            end else begin
                chk("raddr_idle", 64'(o_pp_raddr), 64'd0);
            end
            if (SS_rdy && SS_ack) begin
                if (ss_model < 16) ss_cyc[ss_model] = cyc;
                ss_model++;
            end
            if (o_done) done_cnt++;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_pass(input logic mode, input int size, input logic [7:0] tag);
        rd_model = 0; ss_model = 0; out_cnt = 0; out_cntw = 0;
        i_start = 1'b1; i_mode = mode; i_size = 7'(size); i_tag = tag;
        step();
        i_start = 1'b0;
    endtask

    task automatic ss_writer(input int n, input int gap);
        int  k = 0;
        int  guard = 0;
        logic acked;
        while (k < n && guard < 300) begin
            SS_rdy = 1'b1;
            @(negedge clk);
            acked = SS_ack;
            step();
            guard++;
            if (acked) begin
                k++;
                if (gap > 0 && k < n) begin
                    SS_rdy = 1'b0;
                    repeat (gap) step();
                end
            end
        end
        SS_rdy = 1'b0;
        if (k < n) begin
            total++; bad++;
            $display("FAIL ss_timeout: got %0d writes required %0d", k, n);
        end
    endtask

    task automatic lpe_src(input int first, input int n, input int delay);
        int  k = 0;
        int  guard = 0;
        logic acked;
        repeat (delay) step();
        while (k < n && guard < 300) begin
            LPE_rdy = 1'b1;
            i_lpe_psum = lpe_vec[first+k];
            i_lpe_tag  = lpe_tagv[first+k];
            @(negedge clk);
            acked = LPE_ack;
            step();
            guard++;
            if (acked) k++;
        end
        LPE_rdy = 1'b0;
        if (k < n) begin
            total++; bad++;
            $display("FAIL lpe_timeout: got %0d beats required %0d", k, n);
        end
    endtask

    task automatic wait_done(input int budget);
        int d0 = done_cnt;
        int n = 0;
        while (done_cnt == d0 && n < budget) begin
            step();
            n++;
        end
        if (done_cnt == d0) begin
            total++; bad++;
            $display("FAIL done_timeout: got no o_done within %0d cycles required one", budget);
        end
        step();
        step();
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got no finish required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;
        for (int i = 0; i < 64; i++)
            pp_mem[i] = {16'(16'h1000 + i*4 + 3), 16'(16'h1000 + i*4 + 2),
                         16'(16'h1000 + i*4 + 1), 16'(16'h1000 + i*4)};
        lpe_vec[0] = 64'h0000_1111_2222_3333; lpe_tagv[0] = 8'h51;
        lpe_vec[1] = 64'h4444_5555_6666_7777; lpe_tagv[1] = 8'h52;
        lpe_vec[2] = {16'hFFFF, 16'h0001, 16'h0003, 16'h0020}; lpe_tagv[2] = 8'h53;
        lpe_vec[3] = {16'h0001, 16'hFFFE, 16'h0001, 16'hFFF0}; lpe_tagv[3] = 8'h54;

        // reset
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_pout_rdy", 64'(POUT_rdy), 64'd0);
        chk("rst_pout_psum", o_pout_psum, 64'd0);
        chk("rst_pout_tag", 64'(o_pout_tag), 64'd0);
        chk("rst_done", 64'(o_done), 64'd0);
        chk("rst_busy", 64'(o_busy), 64'd0);
        chk("rst_pp_read", 64'(o_pp_read), 64'd0);
        chk("rst_ss_ack", 64'(SS_ack), 64'd0);
        chk("rst_lpe_ack", 64'(LPE_ack), 64'd0);
        step();

        // 1: MERGE, PP only
        POUT_ack = 1'b1;
        for (int k = 0; k < 4; k++) push_exp(pp_mem[k], pp_mem[k], 8'hA1);
        start_pass(1'b0, 4, 8'hA1);
        ss_writer(4, 0);
        wait_done(100);
        chk("t1_reads", 64'(rd_model), 64'd4);
        chk("t1_outs", 64'(out_cnt), 64'd4);
        chk("t1_done_cnt", 64'(done_cnt), 64'd1);
        for (int k = 0; k < 4; k++) chk("t1_rd_after_ss", 64'(rd_cyc[k]), 64'(ss_cyc[k] + 1));
        chk("t1_lit", out_log[2], 64'h100B_100A_1009_1008);
        chk("t1_busy_after", 64'(o_busy), 64'd0);

        // 2: MERGE, PP and LPE contending
        push_exp(pp_mem[0], pp_mem[0], 8'hA2);
        push_exp(lpe_vec[0], lpe_vec[0], lpe_tagv[0]);
        push_exp(pp_mem[1], pp_mem[1], 8'hA2);
        push_exp(lpe_vec[1], lpe_vec[1], lpe_tagv[1]);
        push_exp(pp_mem[2], pp_mem[2], 8'hA2);
        start_pass(1'b0, 3, 8'hA2);
        fork
            ss_writer(3, 0);
            lpe_src(0, 2, 1);
        join
        wait_done(100);
        chk("t2_outs", 64'(out_cnt), 64'd5);
        chk("t2_done_cnt", 64'(done_cnt), 64'd2);
        chk("t2_lit", out_log[1], 64'h0000_1111_2222_3333);

        // 3: ACCUM, saturating and wrapping instances
        pp_mem[0] = {16'h8000, 16'h1234, 16'hFFFB, 16'h7FF0};
        pp_mem[1] = {16'h0100, 16'h8001, 16'h7FFF, 16'h0005};
        for (int k = 0; k < 2; k++)
            push_exp(accum(pp_mem[k], lpe_vec[2+k], 1'b1), accum(pp_mem[k], lpe_vec[2+k], 1'b0), 8'hA3);
        start_pass(1'b1, 2, 8'hA3);
        fork
            ss_writer(2, 0);
            lpe_src(2, 2, 0);
        join
        wait_done(100);
        chk("t3_outs", 64'(out_cnt), 64'd2);
        chk("t3_sat_hi", 64'(out_log[0][15:0]), 64'h7FFF);
        chk("t3_sat_neg", 64'(out_log[0][31:16]), 64'hFFFE);
        chk("t3_sat_lo", 64'(out_log[0][63:48]), 64'h8000);
        chk("t3_wrap_hi", 64'(out_logw[0][15:0]), 64'h8010);
        chk("t3_wrap_lo", 64'(out_logw[0][63:48]), 64'h7FFF);

        // 4: back-pressure with size 8
        POUT_ack = 1'b0;
        for (int k = 0; k < 8; k++) push_exp(pp_mem[k], pp_mem[k], 8'hA4);
        start_pass(1'b0, 8, 8'hA4);
        ss_writer(8, 0);
        repeat (12) step();
        chk("t4_reads_held", 64'(rd_model), 64'd4);
        chk("t4_pout_rdy", 64'(POUT_rdy), 64'd1);
        chk("t4_busy", 64'(o_busy), 64'd1);
        chk("t4_no_out", 64'(out_cnt), 64'd0);
        POUT_ack = 1'b1;
        wait_done(200);
        chk("t4_reads", 64'(rd_model), 64'd8);
        chk("t4_outs", 64'(out_cnt), 64'd8);
        chk("t4_q_empty", 64'(exp_q.size()), 64'd0);

        // 5: slow SS writer, extra write held off
        for (int k = 0; k < 2; k++) push_exp(pp_mem[k], pp_mem[k], 8'hA5);
        start_pass(1'b0, 2, 8'hA5);
        ss_writer(2, 2);
        SS_rdy = 1'b1;
        @(negedge clk);
        chk("t5_third_ss_ack", 64'(SS_ack), 64'd0);
        chk("t5_busy", 64'(o_busy), 64'd1);
        step();
        SS_rdy = 1'b0;
        wait_done(100);
        chk("t5_ss_gap", 64'(ss_cyc[1] - ss_cyc[0]), 64'd3);
        chk("t5_writes", 64'(ss_model), 64'd2);
        chk("t5_outs", 64'(out_cnt), 64'd2);

        // 6: abort with two beats buffered, then a clean pass
        POUT_ack = 1'b0;
        start_pass(1'b0, 4, 8'hA6);
        ss_writer(2, 0);
        repeat (3) step();
        chk("t6_buffered", 64'(POUT_rdy), 64'd1);
        d0 = done_cnt;
        i_abort = 1'b1;
        step();
        i_abort = 1'b0;
        @(negedge clk);
        chk("t6_busy", 64'(o_busy), 64'd0);
        chk("t6_pout_rdy", 64'(POUT_rdy), 64'd0);
        POUT_ack = 1'b1;
        repeat (5) step();
        chk("t6_no_done", 64'(done_cnt), 64'(d0));
        chk("t6_no_out", 64'(out_cnt), 64'd0);
        push_exp(pp_mem[0], pp_mem[0], 8'hA7);
        start_pass(1'b0, 1, 8'hA7);
        ss_writer(1, 0);
        wait_done(100);
        chk("t6_restart_outs", 64'(out_cnt), 64'd1);
        chk("t6_restart_done", 64'(done_cnt), 64'(d0 + 1));
        chk("final_q_empty", 64'(exp_q.size() + exp_wq.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/psum_path_stage_gen.md
Name: psum_path_stage_gen

Overview:
- Parametrised next-generation partial-sum path stage for the PE array.
- Reads psum-pad (PP) entries in address order once the SS writer has written them, and forwards or accumulates psums arriving from the left PE (LPE).
- Delivers results through a decoupling output FIFO on a rdy/ack output port (POUT).
- Adds what the previous stage lacked: row/width/depth parameters, an ACCUM mode (PP + LPE with saturation), credit-based back-pressure, abort and a done pulse.

Parameters:
PEROW, 4, psum lanes per beat
PSUMDWD, 16, signed psum width per lane
ADDRW, 6, PP address width (max size 2^ADDRW)
TAGW, 8, psum config tag width carried with each beat
OBUF_DEPTH, 4, output FIFO depth (>=2)
SAT, 1, 1: saturating add in ACCUM; 0: wrap

Ports:
i_clk  in  1  clock
i_rst_n  in  1  asynchronous active-low reset
i_start  in  1  start pass; sampled in IDLE only
i_mode  in  1  0 MERGE, 1 ACCUM; latched at start
i_size  in  ADDRW+1  PP entries this pass; latched at start
i_tag  in  TAGW  tag for PP-sourced beats; latched at start
i_stall  in  1  freeze issue
i_abort  in  1  flush and return to IDLE
o_busy  out  1  state != IDLE
o_done  out  1  one-cycle pass-complete pulse
SS_rdy  in  1  SS writer presents a write
SS_ack  out  1  SS write accepted (sequential addresses 0..size-1)
o_pp_read  out  1  PP read strobe
o_pp_raddr  out  ADDRW  PP read address
i_pp_psum  in  PEROW*PSUMDWD  PP read data, valid 1 cycle after o_pp_read
LPE_rdy  in  1  LPE beat valid
LPE_ack  out  1  LPE beat consumed
i_lpe_psum  in  PEROW*PSUMDWD  LPE data
i_lpe_tag  in  TAGW  LPE tag
POUT_rdy  out  1  output FIFO non-empty
POUT_ack  in  1  downstream accepts head
o_pout_psum  out  PEROW*PSUMDWD  FIFO head data
o_pout_tag  out  TAGW  FIFO head tag

Behaviour:
- Handshakes: a transfer occurs when rdy && ack in the same cycle. Ack may depend combinationally on rdy. Rdy holds with stable data until acked.
- Reset: state IDLE; all counters 0; FIFO empty. Outputs: POUT_rdy=0, o_pout_*=0, o_done=0, o_busy=0, o_pp_read=0, o_pp_raddr=0, SS_ack=0, LPE_ack=0.
- FSM states: IDLE, RUN, DONE.
  - IDLE -> RUN on i_start with i_size>0; IDLE -> DONE on i_start with i_size==0.
  - RUN -> DONE when emit_cnt==size, no beat in flight and FIFO empty.
  - DONE -> IDLE unconditionally; o_done=1 in DONE only.
  - i_abort from any state -> IDLE next edge: FIFO and in-flight beat flushed, counters cleared. Abort dominates start, stall and done.
- Counters, each ADDRW+1 bits:
  - ss_cnt: increments on SS transfer.
  - rd_idx: increments on PP read.
  - emit_cnt: increments on each PP-sourced FIFO push.
- SS_ack = RUN && !i_stall && ss_cnt<size. Writes beyond size are held off.
- Credit: issue is allowed only when fifo_cnt + inflight < OBUF_DEPTH (inflight = 1-cycle stage register occupied). At most one issue per cycle.
- pp_ok = RUN && !i_stall && rd_idx<ss_cnt && rd_idx<size && credit.
- MERGE mode:
  - Candidates are a PP read (pp_ok) and an LPE forward (LPE_rdy && credit && !i_stall).
  - On conflict, round-robin: the loser of the last conflict wins next; after reset PP wins first.
  - An LPE forward carries i_lpe_tag; a PP beat carries the latched tag.
- ACCUM mode:
  - Issue requires pp_ok && LPE_rdy together. LPE_ack and o_pp_read are asserted in the same cycle.
  - The LPE beat is registered; next cycle each lane = pp + lpe, signed.
  - With SAT=1, results clamp to [-2^(PSUMDWD-1), 2^(PSUMDWD-1)-1]; with SAT=0 they wrap. Tag = latched tag.
- IDLE/DONE: LPE passthrough only (LPE_ack = LPE_rdy && credit && !i_stall). No PP reads or SS acks.
- o_pp_raddr = rd_idx[ADDRW-1:0] while o_pp_read=1, else 0.
- Latency: issue at cycle T -> stage register T+1 -> FIFO push at end of T+1 -> POUT_rdy visible at T+2.
- FIFO:
  - Simultaneous push and pop at full: legal only when the pop frees the slot. Credit accounting counts in-flight beats, so the FIFO never overflows.
  - Push and pop on empty: no bypass.
- i_stall: blocks issue and SS_ack. In-flight beats complete and the FIFO keeps draining.

Decomposition:
- Shared PE config package: psum_tag typedef (TAGW), mode enum {MERGE, ACCUM}, state enum {IDLE, RUN, DONE}, and a saturating-add function.
- One sub-module: psum_obuf — synchronous FIFO, parameters DEPTH and data width, with push/pop/count/flush.

Test Plan:
- MERGE, size=4, SS writes 0..3 one per cycle, LPE idle, POUT_ack=1 -> raddr 0,1,2,3 issued each one cycle after its SS write. Four PP beats out with i_tag, in order. o_done pulses once.
- MERGE, PP and LPE both ready every cycle, size=3 -> outputs alternate PP, LPE, PP, LPE, PP, starting with PP. LPE beats carry i_lpe_tag.
- ACCUM, SAT=1, PSUMDWD=16, pp=0x7FF0, lpe=0x0020 -> 0x7FFF. pp=-5, lpe=3 -> -2. With SAT=0, 0x7FF0+0x0020 -> 0x8010.
- POUT_ack=0, OBUF_DEPTH=4, size=8 -> exactly 4 beats accepted and no further o_pp_read. Releasing ack drains all 8 in order with no loss or duplication.
- SS slower than reader (one write every 3 cycles) -> rd_idx never exceeds ss_cnt. With size=2, a third SS_rdy gets SS_ack=0.
- i_abort mid-RUN with 2 beats buffered -> IDLE next cycle, POUT_rdy=0, no o_done. A new i_start with size=1 completes normally.
